// File: rtl/uart_rx_mmio.sv
// Memory-mapped 8N1 UART receiver: serial line -> byte FIFO, read through
// a data register (pops) and a status register (clears sticky flags).
module uart_rx_mmio #(
    parameter int          CLKS_PER_BIT = 868,
    parameter int          FIFO_DEPTH   = 8,
    parameter logic [31:0] DATA_ADDR    = 32'hFFFF_FFF8,
    parameter logic [31:0] STAT_ADDR    = 32'hFFFF_FFF4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rxd,
    input  logic [31:0] addr,
    input  logic        rEn,
    output logic        hit,
    output logic [31:0] rData,
    output logic        irq
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [PW:0]   DEPTH_V  = (PW + 1)'(FIFO_DEPTH);
    localparam logic [PW:0]   HALF_V   = (PW + 1)'(FIFO_DEPTH / 2);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    idx, idx_n;
    logic [7:0]    shift, shift_n;
    logic          push_req, frame_set;

    logic          rx_meta, rxs, rxs_prev, armed;
    logic [1:0]    warm;
    logic          fall;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW:0]   wr_ptr, rd_ptr, occ;
    logic          empty, full, count_hi;
    logic          overrun, frame_err;
    logic          data_sel, stat_sel, pop, stat_rd, push_ok, ovr_set;
    logic [31:0]   status;

    // armed only once a genuinely sampled high has been seen, so a line held
    // low across reset release cannot fake a start edge from the reset value
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta  <= 1'b1;
            rxs      <= 1'b1;
            rxs_prev <= 1'b1;
            warm     <= '0;
            armed    <= 1'b0;
        end else begin
            rx_meta  <= rxd;
            rxs      <= rx_meta;
            rxs_prev <= rxs;
            warm     <= {warm[0], 1'b1};
            armed    <= armed | (warm[1] & rxs);
        end
    end

    assign fall = armed & rxs_prev & ~rxs;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shift <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            shift <= shift_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        idx_n     = idx;
        shift_n   = shift;
        push_req  = 1'b0;
        frame_set = 1'b0;
        case (state)
            IDLE: begin
                if (fall) begin
                    state_n = START;
                    cnt_n   = '0;
                end
            end
            START: begin
                if (cnt == HALF_END) begin
                    cnt_n   = '0;
                    idx_n   = '0;
                    state_n = rxs ? IDLE : DATA;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DATA: begin
                if (cnt == BIT_END) begin
                    cnt_n   = '0;
                    shift_n = {rxs, shift[7:1]};
                    idx_n   = idx + 1'b1;
                    if (idx == 3'd7) state_n = STOP;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            STOP: begin
                if (cnt == BIT_END) begin
                    cnt_n = '0;
                    if (rxs) begin
                        push_req = 1'b1;
                        state_n  = IDLE;
                    end else begin
                        frame_set = 1'b1;
                        state_n   = BREAK;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            BREAK: begin
                if (rxs) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign data_sel = (addr == DATA_ADDR);
    assign stat_sel = (addr == STAT_ADDR);
    assign hit      = data_sel | stat_sel;

    assign occ      = wr_ptr - rd_ptr;
    assign empty    = (occ == '0);
    assign full     = (occ == DEPTH_V);
    assign count_hi = (occ >= HALF_V);

    assign pop     = rEn & data_sel & ~empty;
    assign stat_rd = rEn & stat_sel;
    // a pop in the same cycle frees the slot, so a push at full still lands
    assign push_ok = push_req & (~full | pop);
    assign ovr_set = push_req & full & ~pop;

    assign status = {26'b0, count_hi, frame_err, overrun, full, ~empty, 1'b0};

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[PW-1:0]] <= shift;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
            rData     <= '0;
            irq       <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            overrun   <= (overrun   & ~stat_rd) | ovr_set;
            frame_err <= (frame_err & ~stat_rd) | frame_set;
            if (rEn && hit) begin
                if (data_sel)
                    rData <= empty ? '0 : {24'b0, mem[rd_ptr[PW-1:0]]};
                else
                    rData <= status;
            end
            irq <= ~empty;
        end
    end

endmodule
